// File: rtl/lstm_fixed_pkg.sv
// Shared fixed-point defaults, dot-product FSM states and signed data range limits.
package lstm_fixed_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } mac_state_t;

    localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/round_sat.sv
// Round-half-up and saturate a wide accumulator back to the datapath width.
// Purely combinational; o_sat flags that clamping occurred.
module round_sat #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 27
) (
    input  logic signed [ACC_W-1:0]      i_acc,
    output logic signed [DATA_WIDTH-1:0] o_result,
    output logic                         o_sat
);

    localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_EXT = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;

    // The accumulator carries one spare bit, so adding the half-LSB cannot wrap.
    assign w_sum   = i_acc + HALF;
    assign w_shift = w_sum >>> FRAC_BITS;

    always_comb begin
        o_sat    = 1'b0;
        o_result = w_shift[DATA_WIDTH-1:0];
        if (w_shift > MAX_EXT) begin
            o_sat    = 1'b1;
            o_result = MAX_EXT[DATA_WIDTH-1:0];
        end else if (w_shift < MIN_EXT) begin
            o_sat    = 1'b1;
            o_result = MIN_EXT[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fifo_dot_product.sv
// Drains VEC_LEN words from the upstream FIFO, MACs them against weights plus bias, emits rounded result.
// Result valid VEC_LEN+3 cycles after start (plus FIFO-empty stalls); held until result_ready.
module fifo_dot_product #(
    parameter int DATA_WIDTH = lstm_fixed_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = lstm_fixed_pkg::FRAC_BITS,
    parameter int VEC_LEN    = 4,
    localparam int IDX_W     = $clog2(VEC_LEN),
    localparam int ACC_W     = 2*DATA_WIDTH + $clog2(VEC_LEN) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic signed [DATA_WIDTH-1:0] fifo_data,
    output logic        [IDX_W-1:0]      w_addr,
    input  logic signed [DATA_WIDTH-1:0] w_data,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         overflow,
    output logic                         busy
);

    import lstm_fixed_pkg::*;

    localparam int CNT_W = $clog2(VEC_LEN + 1);

    mac_state_t r_state;
    mac_state_t w_next_state;

    logic signed [ACC_W-1:0]        r_acc;
    logic        [CNT_W-1:0]        r_rd_cnt;
    logic        [CNT_W-1:0]        r_mac_cnt;
    logic                           r_pend;
    logic signed [DATA_WIDTH-1:0]   r_result;
    logic                           r_overflow;

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]        w_prod_ext;
    logic signed [ACC_W-1:0]        w_bias_ext;
    logic signed [DATA_WIDTH-1:0]   w_sat_result;
    logic                           w_sat;
    logic                           w_last_mac;

    assign w_prod     = fifo_data * w_data;
    assign w_prod_ext = {{(ACC_W-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}}, bias, {FRAC_BITS{1'b0}}};
    assign w_last_mac = r_pend && (r_mac_cnt == CNT_W'(VEC_LEN - 1));

    round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_W      (ACC_W)
    ) u_round_sat (
        .i_acc    (r_acc),
        .o_result (w_sat_result),
        .o_sat    (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        fifo_rd_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                // Count cap keeps the next vector's words in the FIFO.
                fifo_rd_en = !fifo_empty && (r_rd_cnt < CNT_W'(VEC_LEN));
                if (w_last_mac) begin
                    w_next_state = SAT;
                end
            end
            SAT: begin
                w_next_state = OUT;
            end
            OUT: begin
                if (result_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_rd_cnt   <= '0;
            r_mac_cnt  <= '0;
            r_pend     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc      <= w_bias_ext;
                        r_rd_cnt   <= '0;
                        r_mac_cnt  <= '0;
                        r_pend     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                READ: begin
                    // fifo_data lands one cycle after the pop, so pend lines the MAC up with it.
                    r_pend <= fifo_rd_en;
                    if (fifo_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    end
                    if (r_pend) begin
                        r_acc     <= r_acc + w_prod_ext;
                        r_mac_cnt <= r_mac_cnt + CNT_W'(1);
                    end
                end
                SAT: begin
                    r_result   <= w_sat_result;
                    r_overflow <= w_sat;
                    r_pend     <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_addr       = (r_state == READ) ? r_rd_cnt[IDX_W-1:0] : '0;
    assign result       = r_result;
    assign overflow     = r_overflow;
    assign result_valid = (r_state == OUT);
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_dot_product.sv
// Randomized and directed bench for fifo_dot_product against an arithmetic reference model.
module tb_fifo_dot_product;

    localparam int DW = 12;
    localparam int FB = 8;
    localparam int VL = 4;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic signed [DW-1:0] bias;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic signed [DW-1:0] fifo_data;
    logic        [IW-1:0] w_addr;
    logic signed [DW-1:0] w_data;
    logic signed [DW-1:0] result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 overflow;
    logic                 busy;

    int n_vec = 0;
    int n_bad = 0;

    int v_dat [VL];
    int v_wgt [VL];

    always #5 clk = ~clk;

    fifo_dot_product #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .VEC_LEN(VL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bias         (bias),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data    (fifo_data),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow),
        .busy         (busy)
    );

    // Upstream FIFO with registered data_out, and a registered-read weight memory.
    logic signed [DW-1:0] fmem [0:255];
    logic signed [DW-1:0] wmem [0:VL-1];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic flush  = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk) w_data <= wmem[w_addr];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int d);
        fmem[wr_ptr[7:0]] = d[DW-1:0];
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic ref_dot(input int b, output longint r, output bit o);
        longint acc;
        acc = longint'(b) * 256;
        for (int i = 0; i < VL; i++) acc += longint'(v_dat[i]) * longint'(v_wgt[i]);
        acc = (acc + 128) >>> FB;
        o = 1'b0;
        r = acc;
        if (acc > 2047) begin
            r = 2047;
            o = 1'b1;
        end else if (acc < -2048) begin
            r = -2048;
            o = 1'b1;
        end
    endtask

    task automatic set_vec(input int d0, input int d1, input int d2, input int d3,
                           input int w0, input int w1, input int w2, input int w3);
        v_dat[0] = d0; v_dat[1] = d1; v_dat[2] = d2; v_dat[3] = d3;
        v_wgt[0] = w0; v_wgt[1] = w1; v_wgt[2] = w2; v_wgt[3] = w3;
    endtask

    // pre words are ready at start; the rest arrive after stall empty cycles.
    task automatic run_vec(input string tag, input int b, input int pre, input int stall, input int hold);
        longint exp_r;
        bit     exp_o;
        int     cyc;
        int     exp_lat;
        int     start_rd;
        bit     pushed;
        ref_dot(b, exp_r, exp_o);
        for (int i = 0; i < VL; i++) wmem[i] = v_wgt[i][DW-1:0];
        start_rd = rd_ptr;
        for (int i = 0; i < pre; i++) push(v_dat[i]);
        exp_lat = VL + 3 + ((pre < VL) ? stall : 0);
        result_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bias  = b[DW-1:0];
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        pushed = (pre >= VL);
        while (!result_valid && cyc < 200) begin
            if (!pushed && cyc == 1 + pre + stall) begin
                for (int i = pre; i < VL; i++) push(v_dat[i]);
                pushed = 1'b1;
            end else if (!pushed && cyc >= 1 + pre) begin
                chk({tag, "_stall_rd_en"}, longint'(fifo_rd_en), 0);
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_result"}, longint'(result), exp_r);
        chk({tag, "_overflow"}, longint'(overflow), longint'(exp_o));
        for (int h = 0; h < hold; h++) begin
            if (h == 0) push(12'sh5A5);
            start = (h == 1);
            chk({tag, "_hold_valid"}, longint'(result_valid), 1);
            chk({tag, "_hold_result"}, longint'(result), exp_r);
            chk({tag, "_hold_rd_en"}, longint'(fifo_rd_en), 0);
            @(negedge clk);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, "_valid_drop"}, longint'(result_valid), 0);
        chk({tag, "_idle"}, longint'(busy), 0);
        chk({tag, "_pops"}, rd_ptr - start_rd, VL);
        if (hold > 0) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_result"}, longint'(result), 0);
        chk({tag, "_valid"}, longint'(result_valid), 0);
        chk({tag, "_overflow"}, longint'(overflow), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_rd_en"}, longint'(fifo_rd_en), 0);
        chk({tag, "_w_addr"}, longint'(w_addr), 0);
    endtask

    initial begin
        int b;
        int pre;
        int stall;
        int span;
        rst_n        = 1'b1;
        start        = 1'b0;
        bias         = '0;
        result_ready = 1'b0;
        for (int i = 0; i < VL; i++) wmem[i] = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        set_vec(256, 256, 256, 256, 128, 128, 128, 128);
        run_vec("nominal", 0, VL, 0, 0);
        set_vec(256, -256, 512, 0, 256, 256, 128, 100);
        run_vec("mixed", 64, VL, 0, 0);
        set_vec(-1, 0, 0, 0, 128, 0, 0, 0);
        run_vec("half_up", 0, VL, 0, 0);
        set_vec(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
        run_vec("sat_pos", 0, VL, 0, 0);
        set_vec(-2048, -2048, -2048, -2048, 2047, 2047, 2047, 2047);
        run_vec("sat_neg", 0, VL, 0, 0);
        set_vec(256, 256, 256, 256, 128, 128, 128, 128);
        run_vec("starve", 0, 2, 5, 0);
        set_vec(256, -256, 512, 0, 256, 256, 128, 100);
        run_vec("backpressure", 64, VL, 0, 10);

        // Abort after two pops, then prove no accumulator residue.
        set_vec(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
        for (int i = 0; i < VL; i++) wmem[i] = v_wgt[i][DW-1:0];
        for (int i = 0; i < VL; i++) push(v_dat[i]);
        @(negedge clk);
        start = 1'b1;
        bias  = 12'sd100;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        set_vec(256, 256, 256, 256, 128, 128, 128, 128);
        run_vec("after_rst", 0, VL, 0, 0);

        for (int n = 0; n < 24; n++) begin
            span = (n % 2 == 0) ? 256 : 2048;
            for (int i = 0; i < VL; i++) begin
                v_dat[i] = int'($urandom_range(0, 2*span - 1)) - span;
                v_wgt[i] = int'($urandom_range(0, 2*span - 1)) - span;
            end
            b     = int'($urandom_range(0, 4095)) - 2048;
            pre   = int'($urandom_range(0, VL));
            stall = (pre < VL) ? int'($urandom_range(1, 4)) : 0;
            run_vec("rand", b, pre, stall, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_dot_product.md
# fifo_dot_product

Fixed-point dot-product engine that drains one input vector from the upstream `sync_fifo` and multiplies it element-wise with a weight vector. It accumulates the products with a bias, then rounds and saturates the sum back to the datapath width. It sits directly downstream of `sync_fifo`, driving its `rd_en` from the FIFO's `empty` flag and consuming its registered `data_out`. Results leave through a valid/ready handshake toward the LSTM gate activation stage.

## Interface
- `DATA_WIDTH`, 12: signed two's-complement width of samples, weights, bias and result.
- `FRAC_BITS`, 8: fractional bits of the Q format shared by data, weights, bias and result.
- `VEC_LEN`, 4: elements per dot product; must be ≥2.
- Derived localparams: `IDX_W = $clog2(VEC_LEN)`; `ACC_W = 2*DATA_WIDTH + $clog2(VEC_LEN) + 1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one dot product; sampled only in IDLE.
- `bias`  in  DATA_WIDTH  signed bias; sampled with `start`.
- `fifo_empty`  in  1  upstream FIFO empty flag.
- `fifo_rd_en`  out  1  pop request to FIFO (combinational).
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after a pop.
- `w_addr`  out  IDX_W  weight index; equals the element count of the current pop.
- `w_data`  in  DATA_WIDTH  weight from a registered-read memory; valid one cycle after `w_addr`, aligned with `fifo_data`.
- `result`  out  DATA_WIDTH  rounded, saturated dot product.
- `result_valid`  out  1  `result` and `overflow` are valid.
- `result_ready`  in  1  downstream accepts the result.
- `overflow`  out  1  saturation occurred for this result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State machine:
  - IDLE → READ on `start`: acc ← sign-extended `bias` << FRAC_BITS; rd_cnt ← 0; mac_cnt ← 0; `overflow` ← 0.
  - READ: `fifo_rd_en` = `!fifo_empty && rd_cnt < VEC_LEN`; `w_addr` = rd_cnt. Each pop increments rd_cnt, and the pop is registered into `pend`.
  - READ, MAC path: when `pend` = 1, acc ← acc + signed(`fifo_data`) × signed(`w_data`) and mac_cnt increments. When the MAC with mac_cnt = VEC_LEN−1 completes → SAT.
  - SAT (1 cycle): `result` ← sat(round(acc)), `overflow` ← saturated; → OUT.
  - OUT: `result_valid` = 1. When `result_ready` = 1 → IDLE.
- Round: add 2^(FRAC_BITS−1), then arithmetic shift right by FRAC_BITS (round half up).
- Saturate: clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- `start` outside IDLE is ignored; no queuing.
- FIFO starvation: pops pause while `fifo_empty` = 1, with no timeout. The accumulation result is independent of stall pattern.
- `fifo_rd_en` is never high in IDLE, SAT or OUT, and never after VEC_LEN pops, so no words from the next vector are consumed.
- Reset values: state IDLE, acc 0, counters 0, `pend` 0, `result` 0, `result_valid` 0, `overflow` 0, `busy` 0, `fifo_rd_en` 0, `w_addr` 0.
- Reset mid-operation aborts immediately. Words already popped are discarded. The FIFO is reset separately by the system.

## Timing
- `start` sampled high at the end of cycle 0 → READ in cycle 1.
- With a non-empty FIFO, pops occur in cycles 1..VEC_LEN and MACs in cycles 2..VEC_LEN+1.
- SAT occurs in cycle VEC_LEN+2; `result_valid` rises in cycle VEC_LEN+3 (cycle 7 for VEC_LEN = 4).
- Each empty cycle during READ adds one cycle of latency.
- `result` and `overflow` are held stable while `result_valid` = 1 and `result_ready` = 0.
- The handshake completes on the edge where both are high. `result_valid` drops the next cycle. Minimum start-to-start spacing is VEC_LEN+4 cycles.
- A pop and a MAC in the same cycle are the normal pipelined case, with no conflict.

## Structure
- Shared package `lstm_fixed_pkg` holds:
  - `DATA_WIDTH` and `FRAC_BITS` defaults;
  - the `mac_state_t` enum (IDLE, READ, SAT, OUT);
  - min/max constants for the signed data range.
- One sub-module: `round_sat`, a combinational ACC_W → DATA_WIDTH rounding and saturation block that outputs the saturation flag. The parent FSM registers its output in SAT.

## Test plan
- Nominal: data 256 ×4, weights 128 ×4, bias 0 → `result` = 512, `overflow` = 0, `result_valid` in cycle 7.
- Bias plus mixed signs:
  - data {256, −256, 512, 0}, weights {256, 256, 128, 100}, bias 64 → `result` = 320.
  - data −1, weight 128, all others 0, bias 0 → `result` = 0 (round half up).
- Saturation:
  - data 2047 ×4, weights 2047 ×4 → `result` = 2047, `overflow` = 1.
  - data −2048 ×4, weights 2047 ×4 → `result` = −2048, `overflow` = 1.
- Starvation: 2 words available, FIFO empty for 5 cycles, then 2 more → `fifo_rd_en` low while empty. Result matches the unstalled case; `result_valid` in cycle 12.
- Backpressure plus ignored start: `result_ready` low for 10 cycles with `start` pulsed → `result` stable, no pops. Ready high → IDLE next cycle; the next `start` is accepted.
- Reset mid-vector: `rst_n` low after 2 pops → all outputs at reset values. A fresh vector then yields the correct result with no residue from the aborted accumulation.
